apb_master: RTL and testbench

- APB requester (bridge) that drives the two-slave APB bus from a simple host request/response port.
- Converts each accepted host request into one APB SETUP + ACCESS transfer to slave 1 or slave 2, selected by host address bit 8.
- Holds ACCESS through slave wait states, captures read data, and returns a one-cycle response pulse to the host.
- Supports back-to-back transfers without an IDLE bubble.

---
 rtl/apb_master.sv | 123 ++++++++++++
 tb/tb_apb_master.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester bridging a host request/response port onto a two-slave APB bus.
// Optional ACCESS wait-state timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [8:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2,
  input  logic       PREADY1,
  input  logic       PREADY2
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t r_state;
  logic   r_sel;
  logic   w_sel_ready;
  logic   w_accept;
  logic   w_timeout;
  logic   w_done;

  assign w_sel_ready = r_sel ? PREADY2 : PREADY1;
  assign req_ready   = (r_state == S_IDLE) || ((r_state == S_ACCESS) && w_sel_ready);
  assign w_accept    = req_valid && req_ready;
  assign w_done      = (r_state == S_ACCESS) && w_sel_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [7:0] r_wait;
  logic       r_err;

  assign w_timeout = (r_state == S_ACCESS) && !w_sel_ready &&
                     (r_wait == 8'(TIMEOUT_CYCLES - 1));
  assign rsp_err   = r_err;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      if ((r_state == S_ACCESS) && !w_sel_ready && !w_timeout) r_wait <= r_wait + 8'd1;
      else                                                     r_wait <= '0;
      if (w_done)         r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= S_IDLE;
      r_sel     <= 1'b0;
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: ;
        S_SETUP: begin
          PENABLE <= 1'b1;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_sel_ready) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? 8'h00 : (r_sel ? PRDATA2 : PRDATA1);
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_timeout) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Acceptance (from IDLE or a completing ACCESS) overrides the return to IDLE above.
      if (w_accept) begin
        r_state <= S_SETUP;
        r_sel   <= req_addr[8];
        PSEL1   <= ~req_addr[8];
        PSEL2   <= req_addr[8];
        PENABLE <= 1'b0;
        PWRITE  <= req_write;
        PADDR   <= req_addr[7:0];
        PWDATA  <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master with a simple two-slave APB model.
// The timeout scenario runs only when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       req_valid, req_ready, req_write;
  logic [8:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA1, PRDATA2;
  logic       PREADY1, PREADY2;

  logic [7:0] mem1 [0:255];
  logic [7:0] mem2 [0:255];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  apb_master #(.TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY1(PREADY1), .PREADY2(PREADY2)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Unselected slave gets the opposite ready so a wrong mux shows up.
  task automatic set_ready(input logic sel, input logic v);
    if (sel) begin PREADY2 = v;  PREADY1 = ~v; end
    else     begin PREADY1 = v;  PREADY2 = ~v; end
  endtask

  task automatic xfer(input logic w, input logic [8:0] a, input logic [7:0] wd, input int waits,
                      output logic [7:0] rd, output logic er, output int cyc,
                      output int n1, output int n2, output int nen, output int bad);
    int   acc;
    int   tries;
    logic got;
    logic seen;
    rd = '0; er = 1'b0; cyc = 0; n1 = 0; n2 = 0; nen = 0; bad = 0; acc = 0; tries = 0;
    got = 1'b0; seen = 1'b0;
    @(negedge PCLK);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
    set_ready(a[8], waits == 0);
    PRDATA1 = a[8] ? 8'hEE : mem1[a[7:0]];
    PRDATA2 = a[8] ? mem2[a[7:0]] : 8'hEE;
    while (!got && tries < 50) begin
      #1 got = req_ready;
      @(posedge PCLK);
      tries++;
      if (!got) @(negedge PCLK);
    end
    if (!got) begin
      check("accept_bound", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge PCLK);
      if (k == 0) req_valid = 1'b0;
      cyc++;
      if (PSEL1)   n1++;
      if (PSEL2)   n2++;
      if (PENABLE) nen++;
      if (PSEL1 && PSEL2) bad++;
      if ((PSEL1 || PSEL2) && (PADDR !== a[7:0] || PWRITE !== w || (w && PWDATA !== wd))) bad++;
      if (PENABLE) begin
        acc++;
        if (acc > waits) begin
          set_ready(a[8], 1'b1);
          if (w) begin
            if (a[8]) mem2[a[7:0]] = PWDATA;
            else      mem1[a[7:0]] = PWDATA;
          end
        end
      end
      if (rsp_valid) begin
        rd = rsp_rdata; er = rsp_err; seen = 1'b1;
      end
    end
    if (!seen) check("rsp_bound", 32'd0, 32'd1);
  endtask

  logic [7:0] rd;
  logic       er;
  int         cyc, n1, n2, nen, bad, npulse;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int unsigned i = 0; i < 256; i++) begin mem1[i] = 8'h00; mem2[i] = 8'h00; end
    mem2[8'h0A] = 8'h3C;
    mem2[8'h20] = 8'h99;
    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    PRDATA1 = '0; PRDATA2 = '0; PREADY1 = 1'b0; PREADY2 = 1'b0;
    repeat (2) @(negedge PCLK);
    check("rst_outs", {PSEL1, PSEL2, PENABLE, PWRITE, rsp_valid, rsp_err}, 32'd0);
    check("rst_bus",  {PADDR, PWDATA, rsp_rdata}, 32'd0);
    PRESET = 1'b0;
    #1 check("rst_ready", req_ready, 1);

    // Write then read slave 1, zero wait states
    xfer(1'b1, 9'h005, 8'hA5, 0, rd, er, cyc, n1, n2, nen, bad);
    check("wr1_latency", cyc, 3);
    check("wr1_psel1",   n1, 2);
    check("wr1_psel2",   n2, 0);
    check("wr1_penable", nen, 1);
    check("wr1_rdata",   rd, 8'h00);
    check("wr1_stable",  bad, 0);
    @(negedge PCLK);
    check("wr1_pulse", rsp_valid, 0);
    xfer(1'b0, 9'h005, 8'h00, 0, rd, er, cyc, n1, n2, nen, bad);
    check("rd1_rdata", rd, 8'hA5);
    check("rd1_err",   er, 0);
    check("rd1_latency", cyc, 3);

    // Slave 2 read
    xfer(1'b0, 9'h10A, 8'h00, 0, rd, er, cyc, n1, n2, nen, bad);
    check("rd2_rdata", rd, 8'h3C);
    check("rd2_psel1", n1, 0);
    check("rd2_psel2", n2, 2);
    check("rd2_stable", bad, 0);

    // Four wait states on slave 1
    xfer(1'b1, 9'h033, 8'h5A, 4, rd, er, cyc, n1, n2, nen, bad);
    check("ws_penable", nen, 5);
    check("ws_psel1",   n1, 6);
    check("ws_latency", cyc, 7);
    check("ws_stable",  bad, 0);
    check("ws_err",     er, 0);
    @(negedge PCLK);
    check("ws_pulse", rsp_valid, 0);

    // Back-to-back: write 0x001 then read 0x102 without an IDLE cycle
    npulse = 0;
    @(negedge PCLK);
    PREADY1 = 1'b1; PREADY2 = 1'b1; PRDATA1 = 8'hEE; PRDATA2 = 8'h77;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h001; req_wdata = 8'h11;
    #1 check("b2b_ready_idle", req_ready, 1);
    @(negedge PCLK);
    check("b2b_setup1", {PSEL1, PSEL2, PENABLE}, 3'b100);
    req_write = 1'b0; req_addr = 9'h102;
    #1 check("b2b_ready_setup", req_ready, 0);
    @(negedge PCLK);
    check("b2b_access1", {PSEL1, PSEL2, PENABLE}, 3'b101);
    check("b2b_ready_access", req_ready, 1);
    @(negedge PCLK);
    check("b2b_setup2", {PSEL1, PSEL2, PENABLE, rsp_valid}, 4'b0101);
    check("b2b_paddr2", PADDR, 8'h02);
    if (rsp_valid) npulse++;
    req_valid = 1'b0;
    @(negedge PCLK);
    check("b2b_access2", {PSEL1, PSEL2, PENABLE}, 3'b011);
    if (rsp_valid) npulse++;
    @(negedge PCLK);
    check("b2b_rdata2", rsp_rdata, 8'h77);
    check("b2b_idle", {PSEL1, PSEL2, PENABLE}, 3'b000);
    if (rsp_valid) npulse++;
    @(negedge PCLK);
    if (rsp_valid) npulse++;
    check("b2b_pulses", npulse, 2);

`ifdef APB_MASTER_TIMEOUT_EN
    xfer(1'b0, 9'h120, 8'h00, 255, rd, er, cyc, n1, n2, nen, bad);
    check("to_err",     er, 1);
    check("to_rdata",   rd, 8'h00);
    check("to_penable", nen, 16);
    check("to_latency", cyc, 18);
    check("to_psel_off", {PSEL1, PSEL2, PENABLE}, 3'b000);
    xfer(1'b0, 9'h120, 8'h00, 0, rd, er, cyc, n1, n2, nen, bad);
    check("to_next_rdata", rd, 8'h99);
    check("to_next_err",   er, 0);
`endif

    // Reset asserted mid-ACCESS
    @(negedge PCLK);
    PREADY1 = 1'b0; PREADY2 = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h007;
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    check("rstm_in_access", {PSEL1, PENABLE}, 2'b11);
    #2 PRESET = 1'b1;
    #1 check("rstm_async_drop", {PSEL1, PSEL2, PENABLE}, 3'b000);
    npulse = 0;
    @(negedge PCLK);
    if (rsp_valid) npulse++;
    PRESET = 1'b0; PREADY1 = 1'b1;
    #1 check("rstm_ready", req_ready, 1);
    repeat (3) begin
      @(negedge PCLK);
      if (rsp_valid || PSEL1 || PENABLE) npulse++;
    end
    check("rstm_no_rsp", npulse, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
